// File: rtl/msfsm_evt_pkg.sv
// Shared types for the input event generator: channel state encoding and overrun counter sizing.
// Overrun support is enabled by defining MSFSM_EVT_OVERRUN_EN.
package msfsm_evt_pkg;

  typedef enum logic [1:0] {
    LO     = 2'b00,
    PEND_P = 2'b01,
    HI     = 2'b10,
    PEND_M = 2'b11
  } ch_state_e;

  localparam int OVR_CNT_W = 8;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v,
                                                    input logic en);
    return (en && (v != OVR_CNT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/msfsm_input_event_gen_if.sv
// Event bus between the asynchronous environment, the event generator and the Mealy FSM network.
// overrun/ovr_count exist only when MSFSM_EVT_OVERRUN_EN is defined.
interface msfsm_input_event_gen_if
  import msfsm_evt_pkg::*;
#(
  parameter int N_IN = 2
) ();

  logic [N_IN-1:0] sig_in;
  logic [N_IN-1:0] ack_p;
  logic [N_IN-1:0] ack_m;
  logic [N_IN-1:0] ev_p;
  logic [N_IN-1:0] ev_m;
  logic [N_IN-1:0] sig_level;
`ifdef MSFSM_EVT_OVERRUN_EN
  logic [N_IN-1:0]      overrun;
  logic [OVR_CNT_W-1:0] ovr_count;
`endif

  modport master (
    output sig_in, ack_p, ack_m,
    input  ev_p, ev_m, sig_level
`ifdef MSFSM_EVT_OVERRUN_EN
    , input overrun, ovr_count
`endif
  );

  modport slave (
    input  sig_in, ack_p, ack_m,
    output ev_p, ev_m, sig_level
`ifdef MSFSM_EVT_OVERRUN_EN
    , output overrun, ovr_count
`endif
  );

endinterface

// File: rtl/msfsm_evt_channel.sv
// One input channel: SYNC_STAGES-deep synchronizer feeding a four-state event FSM.
// With MSFSM_EVT_OVERRUN_EN, ovr_hit flags a pending event whose input has reverted.
//
// state  | meaning
// LO     | committed level 0, no event pending
// PEND_P | rising event pending, waiting for ack_p
// HI     | committed level 1, no event pending
// PEND_M | falling event pending, waiting for ack_m
module msfsm_evt_channel
  import msfsm_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_BIT    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  input  logic ack_p,
  input  logic ack_m,
  output logic ev_p,
  output logic ev_m,
  output logic sig_level
`ifdef MSFSM_EVT_OVERRUN_EN
  , output logic ovr_hit
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  ch_state_e              state_q, state_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{INIT_BIT}};
      state_q <= INIT_BIT ? HI : LO;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
    end
  end

  // Acks only matter in their own pending state; a reverted input never cancels a pending event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LO:      if (s)      state_d = PEND_P;
      PEND_P:  if (ack_p)  state_d = HI;
      HI:      if (!s)     state_d = PEND_M;
      PEND_M:  if (ack_m)  state_d = LO;
      default:             state_d = LO;
    endcase
  end

  always_comb begin
    ev_p      = (state_q == PEND_P);
    ev_m      = (state_q == PEND_M);
    sig_level = (state_q == HI) || (state_q == PEND_M);
`ifdef MSFSM_EVT_OVERRUN_EN
    ovr_hit   = ((state_q == PEND_P) && !s) || ((state_q == PEND_M) && s);
`endif
  end

endmodule

// File: rtl/msfsm_input_event_gen.sv
// Turns asynchronous input levels into acknowledged rise/fall events for the Mealy FSM network.
// Optional sticky overrun flags and a saturating overrun counter: define MSFSM_EVT_OVERRUN_EN.
module msfsm_input_event_gen
  import msfsm_evt_pkg::*;
#(
  parameter int              N_IN        = 2,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_IN-1:0] INIT_LEVEL  = {N_IN{1'b0}}
) (
  input  logic                    clk,
  input  logic                    reset,
  msfsm_input_event_gen_if.slave  bus
);

  logic [N_IN-1:0] ev_p_w;
  logic [N_IN-1:0] ev_m_w;
  logic [N_IN-1:0] sig_level_w;
`ifdef MSFSM_EVT_OVERRUN_EN
  logic [N_IN-1:0] ovr_hit_w;
`endif

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    msfsm_evt_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_BIT    (INIT_LEVEL[i])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (bus.sig_in[i]),
      .ack_p     (bus.ack_p[i]),
      .ack_m     (bus.ack_m[i]),
      .ev_p      (ev_p_w[i]),
      .ev_m      (ev_m_w[i]),
      .sig_level (sig_level_w[i])
`ifdef MSFSM_EVT_OVERRUN_EN
      , .ovr_hit (ovr_hit_w[i])
`endif
    );
  end

  assign bus.ev_p      = ev_p_w;
  assign bus.ev_m      = ev_m_w;
  assign bus.sig_level = sig_level_w;

`ifdef MSFSM_EVT_OVERRUN_EN
  logic [N_IN-1:0]      overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0] ovr_count_q, ovr_count_d;

  // Simultaneous hits on several channels count once per cycle.
  always_comb begin
    overrun_d   = overrun_q | ovr_hit_w;
    ovr_count_d = sat_inc(ovr_count_q, |ovr_hit_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= '0;
      ovr_count_q <= '0;
    end else begin
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign bus.overrun   = overrun_q;
  assign bus.ovr_count = ovr_count_q;
`endif

endmodule

// File: doc/msfsm_input_event_gen.md
MSFSM_INPUT_EVENT_GEN -- requirements
Module: msfsm_input_event_gen

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of asynchronous STG input signals (bit 0 = a, bit 1 = b).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-003 SHALL have parameter INIT_LEVEL, default {N_IN{1'b0}}, per-input level assumed at reset.
REQ-004 SHALL have port clk  in  1  system clock; all state changes on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sig_in  in  N_IN  asynchronous input levels from the environment.
REQ-007 SHALL have port ev_p  out  N_IN  pending rising event per input; drives the x_P_ inputs of the Mealy FSMs.
REQ-008 SHALL have port ev_m  out  N_IN  pending falling event per input; drives the x_M_ inputs of the Mealy FSMs.
REQ-009 SHALL have port ack_p  in  N_IN  one-cycle pulse; the FSM network consumed the rising event.
REQ-010 SHALL have port ack_m  in  N_IN  one-cycle pulse; the FSM network consumed the falling event.
REQ-011 SHALL have port sig_level  out  N_IN  last consumed (committed) level per input.
REQ-012 SHALL have port overrun  out  N_IN  sticky overrun flag (present only with MSFSM_EVT_OVERRUN_EN).
REQ-013 SHALL have port ovr_count  out  8  saturating overrun counter over all inputs (present only with MSFSM_EVT_OVERRUN_EN).

Function
REQ-014 SHALL pass each sig_in bit through a SYNC_STAGES flop chain; the last stage is the sampled level s.
REQ-015 SHALL run one four-state channel FSM per input: LO, PEND_P, HI, PEND_M.
REQ-016 SHALL take these transitions: LO & s=1 -> PEND_P; PEND_P & ack_p -> HI; HI & s=0 -> PEND_M; PEND_M & ack_m -> LO; otherwise hold.
REQ-017 SHALL decode all outputs from registered state: ev_p=1 only in PEND_P; ev_m=1 only in PEND_M; sig_level=1 in HI and PEND_M.
REQ-018 SHALL assert ev_p exactly SYNC_STAGES+1 clk edges after the first edge that samples a sig_in rise; the same latency applies to falls and ev_m.
REQ-019 SHALL keep an event pending until acknowledged; a pending event is never withdrawn when s reverts.
REQ-020 SHALL, when s reverts while an event is pending, leave the state unchanged; after the ack the opposite event is raised on the next cycle (HI & s=0 -> PEND_M).
REQ-021 SHALL ignore ack_p outside PEND_P and ack_m outside PEND_M.
REQ-022 SHALL apply only the matching ack when ack_p and ack_m arrive together.
REQ-023 SHALL never assert ev_p and ev_m together on the same channel.
REQ-024 SHALL treat an input pulse shorter than one clk period as best-effort: it is either missed or produces a full event pair.

Reset
REQ-025 SHALL, on reset, load every synchronizer stage with INIT_LEVEL and set each channel to LO (INIT_LEVEL=0) or HI (INIT_LEVEL=1).
REQ-026 SHALL therefore hold ev_p=0, ev_m=0, sig_level=INIT_LEVEL, overrun=0 and ovr_count=0 out of reset.
REQ-027 SHALL, on reset mid-operation, discard pending events and take precedence over any ack in the same cycle.

Configuration
REQ-028 SHALL, when MSFSM_EVT_OVERRUN_EN is defined, set overrun[i] and increment ovr_count (saturating at 255) on each cycle where channel i is pending and s differs from its value at event entry; multiple channels in one cycle add one count in total.
REQ-029 SHALL, when MSFSM_EVT_OVERRUN_EN is undefined, omit the overrun and ovr_count ports and their logic; the event behaviour is identical in both builds.

Structure
REQ-030 SHALL place the channel state enum (LO=2'b00, PEND_P=2'b01, HI=2'b10, PEND_M=2'b11) and the ovr_count width constant in shared package msfsm_evt_pkg.
REQ-031 SHALL implement one channel (synchronizer plus FSM) as sub-module msfsm_evt_channel, instantiated N_IN times in a generate loop.

Verification
REQ-032 SHALL verify that sig_in=2'b01 after reset with SYNC_STAGES=2 gives ev_p[0]=1 three edges later; ack_p[0] then gives ev_p[0]=0 and sig_level[0]=1 next cycle.
REQ-033 SHALL verify that sig_in[0] rising then falling 2 cycles later with no ack keeps ev_p[0]=1 and ev_m[0]=0; ack_p[0] then gives ev_m[0]=1 one cycle after the HI state.
REQ-034 SHALL verify that ack_m[1] with channel 1 in LO leaves all state unchanged.
REQ-035 SHALL verify that INIT_LEVEL=2'b10 with sig_in=2'b10 held through reset generates no events and gives sig_level=2'b10.
REQ-036 SHALL verify, with MSFSM_EVT_OVERRUN_EN, that 300 revert cycles give ovr_count=255 and overrun[0]=1; reset then clears both.
REQ-037 SHALL verify that reset asserted while in PEND_P, with ack_p in the same cycle, gives LO and ev_p=0 the next cycle.
